// File: rtl/hnull_source_pkg.sv
// Shared types and default sizes for the synthetic message source.
// Sizes mirror the fabric-wide defaults; the FSM encoding lives here too.
package hnull_source_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 16;
    localparam int NS_REDUN_SIZE   = 4;
    localparam int NS_REQ_CKS      = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_REL,
        ST_DONE
    } state_e;

    // An unbounded stream counts modulo the data field width.
    function automatic int cnt_width(input int msg_cnt, input int dsz);
        return (msg_cnt == 0) ? dsz : $clog2(msg_cnt + 1);
    endfunction

endpackage

// File: rtl/hnull_source_if.sv
// Outgoing four-phase req/ack channel carrying one packed message.
// Master drives req and data, slave answers with ack.
interface hnull_source_if #(
    parameter int DW = 8
) ();
    logic          snd0_req_out;
    logic          snd0_ack_in;
    logic [DW-1:0] snd0_data_out;

    modport master (
        output snd0_req_out,
        output snd0_data_out,
        input  snd0_ack_in
    );

    modport slave (
        input  snd0_req_out,
        input  snd0_data_out,
        output snd0_ack_in
    );
endinterface

// File: rtl/hnull_source_hdebouncer.sv
// Level filter: ckd_sig follows sig after CKS stable cycles, no synchroniser.
// Ready once the filtered level first agrees with the input; no backpressure.
module hnull_source_hdebouncer #(
    parameter int CKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic ckd_sig,
    output logic rdy
);
    localparam int CW = $clog2(CKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ckd_q, ckd_d;
    logic          rdy_q, rdy_d;

    // A level held high through reset keeps rdy low until it has been adopted.
    always_comb begin
        cnt_d = '0;
        ckd_d = ckd_q;
        rdy_d = rdy_q | (sig == ckd_q);
        if (sig != ckd_q) begin
            if (cnt_q == CW'(CKS - 1)) begin
                ckd_d = sig;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ckd_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ckd_q <= ckd_d;
            rdy_q <= rdy_d;
        end
    end

    assign ckd_sig = ckd_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/hnull_source.sv
// Numbered message generator on one four-phase channel; data leads req by one cycle.
// One message in flight; waits on the debounced ack for each phase, stalls indefinitely.
module hnull_source
    import hnull_source_pkg::*;
#(
    parameter int ASZ         = NS_ADDRESS_SIZE,
    parameter int DSZ         = NS_DATA_SIZE,
    parameter int RSZ         = NS_REDUN_SIZE,
    parameter int SRC_ADDR    = 0,
    parameter int DST_ADDR    = 1,
    parameter int MSG_CNT     = 0,
    parameter int SND_ACK_CKS = NS_REQ_CKS
) (
    input  logic            gch_clk,
    input  logic            gch_reset,
    output logic            gch_ready,
    hnull_source_if.master  snd0,
    output logic            src_done
);
    localparam int KW = cnt_width(MSG_CNT, DSZ);
    localparam int DW = 2 * ASZ + DSZ + RSZ;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] data_q, data_d;
    logic          req_q, req_d;
    logic          done_q, done_d;
    logic          init_rdy_q, init_rdy_d;

    logic          ckd_ack;
    logic          dbnc_rdy;

    logic [ASZ-1:0] src_f;
    logic [ASZ-1:0] dst_f;
    logic [DSZ-1:0] dat_f;
    logic [RSZ-1:0] red_f;
    logic [DW-1:0]  msg;
    logic           last_msg;

    hnull_source_hdebouncer #(
        .CKS (SND_ACK_CKS)
    ) u_ack_dbnc (
        .clk     (gch_clk),
        .reset   (gch_reset),
        .sig     (snd0.snd0_ack_in),
        .ckd_sig (ckd_ack),
        .rdy     (dbnc_rdy)
    );

    assign src_f    = ASZ'(SRC_ADDR);
    assign dst_f    = ASZ'(DST_ADDR);
    assign dat_f    = DSZ'(k_q);
    assign red_f    = dat_f[RSZ-1:0] ^ src_f[RSZ-1:0] ^ dst_f[RSZ-1:0];
    assign msg      = {dst_f, src_f, dat_f, red_f};
    assign last_msg = (MSG_CNT != 0) && (k_q == KW'(MSG_CNT));

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        data_d     = data_q;
        req_d      = req_q;
        done_d     = done_q;
        init_rdy_d = init_rdy_q;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_IDLE;
                init_rdy_d = 1'b1;
            end
            ST_IDLE: begin
                // A stale high ack from the receiver parks us here until it clears.
                if (dbnc_rdy && !ckd_ack) begin
                    state_d = ST_LOAD;
                    data_d  = msg;
                end
            end
            ST_LOAD: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
            end
            ST_REQ: begin
                if (ckd_ack) begin
                    state_d = ST_REL;
                    req_d   = 1'b0;
                    k_d     = k_q + 1'b1;
                end
            end
            ST_REL: begin
                if (!ckd_ack) begin
                    if (last_msg) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        data_d  = msg;
                    end
                end
            end
            ST_DONE: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            state_q    <= ST_INIT;
            k_q        <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            init_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            data_q     <= data_d;
            req_q      <= req_d;
            done_q     <= done_d;
            init_rdy_q <= init_rdy_d;
        end
    end

    assign gch_ready          = init_rdy_q & dbnc_rdy;
    assign snd0.snd0_req_out  = req_q;
    assign snd0.snd0_data_out = data_q;
    assign src_done           = done_q;

endmodule

// File: tb/tb_hnull_source.sv
// Two sources side by side: a bounded 3-message stream and an unbounded 4-bit stream
// exercising wrap, ack glitches, stale ack at start-up and reset mid-handshake.
module tb_hnull_source;

    localparam int A_ASZ = 8, A_DSZ = 8, A_RSZ = 4, A_SRC = 5,  A_DST = 9,  A_CNT = 3, A_CKS = 2;
    localparam int B_ASZ = 6, B_DSZ = 4, B_RSZ = 3, B_SRC = 13, B_DST = 50, B_CKS = 3;
    localparam int WA = 2 * A_ASZ + A_DSZ + A_RSZ;
    localparam int WB = 2 * B_ASZ + B_DSZ + B_RSZ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic ready_a, ready_b, done_a, done_b;

    hnull_source_if #(.DW(WA)) ifa ();
    hnull_source_if #(.DW(WB)) ifb ();

    hnull_source #(
        .ASZ(A_ASZ), .DSZ(A_DSZ), .RSZ(A_RSZ), .SRC_ADDR(A_SRC), .DST_ADDR(A_DST),
        .MSG_CNT(A_CNT), .SND_ACK_CKS(A_CKS)
    ) u_a (
        .gch_clk(clk), .gch_reset(rst_a), .gch_ready(ready_a), .snd0(ifa), .src_done(done_a)
    );

    hnull_source #(
        .ASZ(B_ASZ), .DSZ(B_DSZ), .RSZ(B_RSZ), .SRC_ADDR(B_SRC), .DST_ADDR(B_DST),
        .MSG_CNT(0), .SND_ACK_CKS(B_CKS)
    ) u_b (
        .gch_clk(clk), .gch_reset(rst_b), .gch_ready(ready_b), .snd0(ifb), .src_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference message: fields laid out by plain arithmetic from the message number.
    function automatic logic [63:0] msg(input int asz, input int dsz, input int rsz,
                                        input int src, input int dst, input int k);
        logic [63:0] s, d, dt, rd;
        s  = 64'(src);
        d  = 64'(dst);
        dt = 64'(k) % (64'd1 << dsz);
        rd = (dt ^ s ^ d) % (64'd1 << rsz);
        return (d << (asz + dsz + rsz)) | (s << (dsz + rsz)) | (dt << rsz) | rd;
    endfunction

    function automatic logic [63:0] exp_msg(input int sel, input int k);
        return sel ? msg(B_ASZ, B_DSZ, B_RSZ, B_SRC, B_DST, k)
                   : msg(A_ASZ, A_DSZ, A_RSZ, A_SRC, A_DST, k);
    endfunction

    function automatic logic req_of(input int sel);
        return sel ? ifb.snd0_req_out : ifa.snd0_req_out;
    endfunction

    function automatic logic ack_of(input int sel);
        return sel ? ifb.snd0_ack_in : ifa.snd0_ack_in;
    endfunction

    function automatic logic rst_of(input int sel);
        return sel ? rst_b : rst_a;
    endfunction

    function automatic logic [63:0] data_of(input int sel);
        return sel ? 64'(ifb.snd0_data_out) : 64'(ifa.snd0_data_out);
    endfunction

    task automatic set_ack(input int sel, input logic v);
        if (sel != 0) ifb.snd0_ack_in = v;
        else          ifa.snd0_ack_in = v;
    endtask

    task automatic wait_req(input int sel, input logic lvl, output int cyc);
        cyc = 0;
        while (req_of(sel) !== lvl && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("req_wait%0d_lvl%0d", sel, lvl), 64'(req_of(sel)), 64'(lvl));
    endtask

    // One receiver handshake; optionally a one-cycle ack glitch before the real ack.
    task automatic hs(input int sel, input int k, input bit glitch);
        int          cyc;
        int          cks;
        logic [63:0] d;
        cks = sel ? B_CKS : A_CKS;
        wait_req(sel, 1'b1, cyc);
        d = data_of(sel);
        chk($sformatf("msg%0d_k%0d", sel, k), d, exp_msg(sel, k));
        if (glitch) begin
            @(negedge clk); set_ack(sel, 1'b1);
            @(negedge clk); set_ack(sel, 1'b0);
            repeat (6) @(negedge clk);
            chk("glitch_req", 64'(req_of(sel)), 64'd1);
            chk("glitch_data", data_of(sel), d);
        end
        @(negedge clk); set_ack(sel, 1'b1);
        wait_req(sel, 1'b0, cyc);
        chk($sformatf("req_fall_lat%0d", sel), 64'(cyc), 64'(cks + 1));
        @(negedge clk); set_ack(sel, 1'b0);
    endtask

    logic [63:0] prev_d [2];
    bit          act    [2] = '{0, 0};

    // Data must not move while either req or ack is high.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_of(s) && act[s] && (req_of(s) || ack_of(s)))
                chk($sformatf("stable%0d", s), data_of(s), prev_d[s]);
            act[s]    = !rst_of(s) && (req_of(s) || ack_of(s));
            prev_d[s] = data_of(s);
        end
    end

    bit done_b_seen = 1'b0;
    bit req_after_done_a = 1'b0;
    always @(posedge clk) begin
        if (done_b === 1'b1) done_b_seen = 1'b1;
        if (done_a === 1'b1 && ifa.snd0_req_out !== 1'b0) req_after_done_a = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_ack(0, 1'b0);
        set_ack(1, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_req_a",   64'(ifa.snd0_req_out), 64'd0);
        chk("rst_data_a",  data_of(0), 64'd0);
        chk("rst_done_a",  64'(done_a), 64'd0);
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_req_b",   64'(ifb.snd0_req_out), 64'd0);
        chk("rst_ready_b", 64'(ready_b), 64'd0);

        // Bounded stream: first-message timing, then three full handshakes.
        rst_a = 1'b0;
        @(negedge clk);
        chk("e0_ready_a", 64'(ready_a), 64'd1);
        chk("e0_data_a",  data_of(0), 64'd0);
        @(negedge clk);
        chk("e1_data_a",  data_of(0), exp_msg(0, 0));
        chk("e1_req_a",   64'(ifa.snd0_req_out), 64'd0);
        @(negedge clk);
        chk("e2_req_a",   64'(ifa.snd0_req_out), 64'd1);
        chk("e2_done_a",  64'(done_a), 64'd0);
        for (int k = 0; k < A_CNT; k++) hs(0, k, 1'b0);
        repeat (12) @(negedge clk);
        chk("done_a",        64'(done_a), 64'd1);
        chk("done_req_a",    64'(ifa.snd0_req_out), 64'd0);
        chk("req_after_done", 64'(req_after_done_a), 64'd0);

        // Unbounded stream released with a stale high ack.
        rst_b = 1'b0;
        @(negedge clk);
        chk("stale_ready_b", 64'(ready_b), 64'd0);
        repeat (8) @(negedge clk);
        chk("stale_req_b",    64'(ifb.snd0_req_out), 64'd0);
        chk("stale_data_b",   data_of(1), 64'd0);
        chk("stale_ready_b2", 64'(ready_b), 64'd1);
        set_ack(1, 1'b0);
        repeat (B_CKS) @(negedge clk);
        chk("stale_hold_b", data_of(1), 64'd0);
        @(negedge clk);
        chk("stale_load_b", data_of(1), exp_msg(1, 0));
        @(negedge clk);
        chk("stale_req1_b", 64'(ifb.snd0_req_out), 64'd1);
        for (int k = 0; k < 5; k++) hs(1, k, k == 1);

        // Reset while message 5 is requesting.
        wait_req(1, 1'b1, cyc);
        chk("pre_rst_msg5", data_of(1), exp_msg(1, 5));
        rst_b = 1'b1;
        @(negedge clk);
        chk("midrst_req_b",   64'(ifb.snd0_req_out), 64'd0);
        chk("midrst_data_b",  data_of(1), 64'd0);
        chk("midrst_ready_b", 64'(ready_b), 64'd0);
        rst_b = 1'b0;
        for (int k = 0; k < 20; k++) hs(1, k, 1'b0);
        chk("never_done_b", 64'(done_b_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
